// File: rtl/i2s_pkg.sv
// Shared I2S frame constants and receiver state encoding.
// Used by both the receive and transmit paths so slot widths stay matched.
package i2s_pkg;

    localparam int I2S_WORD    = 32;
    localparam int I2S_BITSIZE = 16;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        SYNC,
        LEFT,
        RIGHT
    } rx_state_e;

endpackage

// File: rtl/i2s_slot_deser.sv
// Per-slot deserialiser: MSB-first shift with bit and slot-length counters.
// Restarts on every lrclk edge; the edge cycle carries the previous LSB.
module i2s_slot_deser
    import i2s_pkg::*;
#(
    parameter int BITSIZE = I2S_BITSIZE,
    parameter int WORD    = I2S_WORD
) (
    input  logic               sclk,
    input  logic               rst,
    input  logic               edge_i,
    input  logic               sdata_i,
    output logic [BITSIZE-1:0] word_o,
    output logic               bit_full_o,
    output logic               len_ok_o
);

    localparam int CW = $clog2(BITSIZE + 1);
    localparam int LW = $clog2(2 * WORD + 1);

    localparam logic [CW-1:0] CNT_FULL = CW'(BITSIZE);
    localparam logic [LW-1:0] LEN_SAT  = LW'(2 * WORD);
    localparam logic [LW-1:0] LEN_NOM  = LW'(WORD);

    logic [CW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [LW-1:0]      slot_len_q, slot_len_d;
    logic [BITSIZE-1:0] shift_q, shift_d;

    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        slot_len_d = slot_len_q;
        shift_d    = shift_q;
        if (edge_i) begin
            bit_cnt_d  = '0;
            shift_d    = '0;
            slot_len_d = LW'(1);
        end else begin
            if (bit_cnt_q != CNT_FULL) begin
                shift_d   = {shift_q[BITSIZE-2:0], sdata_i};
                bit_cnt_d = bit_cnt_q + CW'(1);
            end
            if (slot_len_q != LEN_SAT) begin
                slot_len_d = slot_len_q + LW'(1);
            end
        end
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            bit_cnt_q  <= '0;
            slot_len_q <= '0;
            shift_q    <= '0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            slot_len_q <= slot_len_d;
            shift_q    <= shift_d;
        end
    end

    assign word_o     = shift_q;
    assign bit_full_o = (bit_cnt_q == CNT_FULL);
    assign len_ok_o   = (slot_len_q == LEN_NOM);

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: aligns to a left-slot start and publishes stereo pairs.
// Left word is held until the right word completes, then both update together.
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int BITSIZE = I2S_BITSIZE,
    parameter int WORD    = I2S_WORD
) (
    input  logic               sclk,
    input  logic               rst,
    input  logic               lrclk,
    input  logic               sdata,
    output logic [BITSIZE-1:0] left_chan,
    output logic [BITSIZE-1:0] right_chan,
    output logic               sample_valid,
    output logic               locked,
    output logic               frame_err
);

    logic lrclk_q;
    logic fall;
    logic rise;
    logic lr_edge;

    logic [BITSIZE-1:0] word;
    logic               bit_full;
    logic               len_ok;

    rx_state_e state_q, state_d;

    logic [BITSIZE-1:0] left_hold_q, left_hold_d;
    logic [BITSIZE-1:0] left_q, left_d;
    logic [BITSIZE-1:0] right_q, right_d;
    logic               valid_q, valid_d;
    logic               locked_q, locked_d;
    logic               err_q, err_d;
    logic               bad_q, bad_d;

    assign fall    = (lrclk_q == CH_RIGHT) && (lrclk == CH_LEFT);
    assign rise    = (lrclk_q == CH_LEFT) && (lrclk == CH_RIGHT);
    assign lr_edge = fall | rise;

    i2s_slot_deser #(
        .BITSIZE (BITSIZE),
        .WORD    (WORD)
    ) u_deser (
        .sclk       (sclk),
        .rst        (rst),
        .edge_i     (lr_edge),
        .sdata_i    (sdata),
        .word_o     (word),
        .bit_full_o (bit_full),
        .len_ok_o   (len_ok)
    );

    always_ff @(posedge sclk) begin
        if (rst) begin
            lrclk_q     <= 1'b0;
            state_q     <= SYNC;
            left_hold_q <= '0;
            left_q      <= '0;
            right_q     <= '0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
            bad_q       <= 1'b0;
        end else begin
            lrclk_q     <= lrclk;
            state_q     <= state_d;
            left_hold_q <= left_hold_d;
            left_q      <= left_d;
            right_q     <= right_d;
            valid_q     <= valid_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
            bad_q       <= bad_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SYNC:    if (fall) state_d = LEFT;
            LEFT:    if (rise) state_d = RIGHT;
            RIGHT:   if (fall) state_d = LEFT;
            default: state_d = SYNC;
        endcase
    end

    always_comb begin
        left_hold_d = left_hold_q;
        left_d      = left_q;
        right_d     = right_q;
        valid_d     = 1'b0;
        locked_d    = locked_q;
        err_d       = err_q;
        bad_d       = bad_q;
        // Partial slots seen while still hunting are not errors.
        if (lr_edge && state_q != SYNC && !len_ok) begin
            err_d = 1'b1;
        end
        unique case (state_q)
            SYNC: begin
                if (fall) locked_d = 1'b1;
            end
            LEFT: begin
                if (rise) begin
                    if (bit_full) begin
                        left_hold_d = word;
                    end else begin
                        err_d = 1'b1;
                        bad_d = 1'b1;
                    end
                end
            end
            RIGHT: begin
                if (fall) begin
                    if (!bad_q && bit_full) begin
                        left_d  = left_hold_q;
                        right_d = word;
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    bad_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign left_chan    = left_q;
    assign right_chan   = right_q;
    assign sample_valid = valid_q;
    assign locked       = locked_q;
    assign frame_err    = err_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Randomised bench for i2s_rx with a slot-level reference model.
// Frames are described as slot lists; pulses/errors are predicted per slot.
module tb_i2s_rx;
    import i2s_pkg::*;

    localparam int BS = I2S_BITSIZE;
    localparam int WD = I2S_WORD;

    logic          sclk = 1'b0;
    logic          rst = 1'b1;
    logic          lrclk = 1'b0;
    logic          sdata = 1'b0;
    logic [BS-1:0] left_chan;
    logic [BS-1:0] right_chan;
    logic          sample_valid;
    logic          locked;
    logic          frame_err;

    always #5 sclk = ~sclk;

    i2s_rx #(
        .BITSIZE (BS),
        .WORD    (WD)
    ) dut (
        .sclk         (sclk),
        .rst          (rst),
        .lrclk        (lrclk),
        .sdata        (sdata),
        .left_chan    (left_chan),
        .right_chan   (right_chan),
        .sample_valid (sample_valid),
        .locked       (locked),
        .frame_err    (frame_err)
    );

    typedef struct {
        logic          lr;
        int            len;
        logic [BS-1:0] val;
    } slot_t;

    slot_t         sq[$];
    int            st[$];
    int            ptag[$];
    logic [BS-1:0] pl[$];
    logic [BS-1:0] pr[$];

    int dcount = 0;
    int checks = 0;
    int errors = 0;

    // One sclk cycle: observe last posedge's outputs, then drive inputs.
    task automatic step(input logic lr, input logic sd, input logic r);
        @(negedge sclk);
        if (sample_valid === 1'b1) begin
            ptag.push_back(dcount - 1);
            pl.push_back(left_chan);
            pr.push_back(right_chan);
        end
        rst   = r;
        lrclk = lr;
        sdata = sd;
        dcount++;
    endtask

    task automatic clear_q();
        sq.delete();
        st.delete();
        ptag.delete();
        pl.delete();
        pr.delete();
    endtask

    task automatic do_reset(input logic lr);
        step(lr, 1'b0, 1'b1);
        clear_q();
    endtask

    task automatic add_slot(input logic lr, input int len,
                            input logic [BS-1:0] v);
        slot_t s;
        s.lr  = lr;
        s.len = len;
        s.val = v;
        sq.push_back(s);
    endtask

    task automatic send_slots();
        logic          sd;
        logic [BS-1:0] v;
        foreach (sq[i]) begin
            st.push_back(dcount);
            v = sq[i].val;
            for (int j = 0; j < sq[i].len; j++) begin
                if (j >= 1 && j <= BS) sd = v[BS-j];
                else sd = 1'($urandom);
                step(sq[i].lr, sd, 1'b0);
            end
        end
        step(sq[sq.size()-1].lr, 1'b0, 1'b0);
    endtask

    task automatic check_scenario(input string name);
        int            first_fall;
        bit            fa[$];
        bit            f;
        bit            eerr;
        int            etag[$];
        logic [BS-1:0] el[$];
        logic [BS-1:0] er[$];
        int            n;
        first_fall = -1;
        eerr = 1'b0;
        foreach (sq[i]) begin
            f = (sq[i].lr == 1'b0) && (i > 0) && (sq[i-1].lr == 1'b1);
            fa.push_back(f);
            if (f && first_fall < 0) first_fall = i;
        end
        for (int i = 1; i < sq.size(); i++) begin
            if (first_fall >= 0 && first_fall <= i - 1 && sq[i-1].len != WD)
                eerr = 1'b1;
        end
        for (int i = 2; i < sq.size(); i++) begin
            if (fa[i] && fa[i-2] && sq[i-1].lr == 1'b1 &&
                sq[i-2].len > BS && sq[i-1].len > BS) begin
                etag.push_back(st[i]);
                el.push_back(sq[i-2].val);
                er.push_back(sq[i-1].val);
            end
        end
        checks++;
        if (ptag.size() != etag.size()) begin
            errors++;
            $display("FAIL %s pulse_count got %0d want %0d",
                     name, ptag.size(), etag.size());
        end
        n = (ptag.size() < etag.size()) ? ptag.size() : etag.size();
        for (int k = 0; k < n; k++) begin
            checks++;
            if (ptag[k] != etag[k]) begin
                errors++;
                $display("FAIL %s pulse%0d_cycle got %0d want %0d",
                         name, k, ptag[k], etag[k]);
            end
            checks++;
            if (pl[k] !== el[k]) begin
                errors++;
                $display("FAIL %s pulse%0d_left got %h want %h",
                         name, k, pl[k], el[k]);
            end
            checks++;
            if (pr[k] !== er[k]) begin
                errors++;
                $display("FAIL %s pulse%0d_right got %h want %h",
                         name, k, pr[k], er[k]);
            end
        end
        checks++;
        if (frame_err !== eerr) begin
            errors++;
            $display("FAIL %s frame_err got %b want %b", name, frame_err, eerr);
        end
        checks++;
        if (locked !== (first_fall >= 0)) begin
            errors++;
            $display("FAIL %s locked got %b want %b",
                     name, locked, first_fall >= 0);
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (left_chan !== '0 || right_chan !== '0) begin
            errors++;
            $display("FAIL %s chans got %h/%h want 0/0",
                     name, left_chan, right_chan);
        end
        checks++;
        if (sample_valid !== 1'b0 || locked !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL %s flags got v%b l%b e%b want 000",
                     name, sample_valid, locked, frame_err);
        end
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 1'b1);
        @(posedge sclk);
        #1;
        check_zero("reset");
    endtask

    task automatic test_nominal();
        do_reset(1'b1);
        add_slot(1'b1, WD, '0);
        for (int i = 0; i < 4; i++) begin
            add_slot(1'b0, WD, 16'hA5C3);
            add_slot(1'b1, WD, 16'h1234);
        end
        add_slot(1'b0, 3, '0);
        send_slots();
        check_scenario("nominal");
    endtask

    task automatic test_extremes();
        do_reset(1'b1);
        add_slot(1'b1, WD, '0);
        add_slot(1'b0, WD, 16'h8000);
        add_slot(1'b1, WD, 16'h7FFF);
        add_slot(1'b0, WD, 16'hFFFF);
        add_slot(1'b1, WD, 16'h0000);
        add_slot(1'b0, 3, '0);
        send_slots();
        check_scenario("extremes");
    endtask

    task automatic test_reset_mid();
        logic [BS-1:0] v;
        do_reset(1'b1);
        add_slot(1'b1, WD, '0);
        add_slot(1'b0, WD, 16'hA5C3);
        add_slot(1'b1, WD, 16'h1234);
        add_slot(1'b0, WD, 16'h5A5A);
        send_slots();
        v = 16'hC3C3;
        step(1'b1, 1'b0, 1'b0);
        for (int j = 1; j <= 8; j++) step(1'b1, v[BS-j], 1'b0);
        step(1'b1, v[BS-9], 1'b1);
        @(posedge sclk);
        #1;
        check_zero("reset_mid");
        clear_q();
        add_slot(1'b1, WD - 10, 16'hFFFF);
        add_slot(1'b0, WD, 16'h1357);
        add_slot(1'b1, WD, 16'h2468);
        add_slot(1'b0, WD, 16'h9ABC);
        add_slot(1'b1, WD, 16'hDEF0);
        add_slot(1'b0, 3, '0);
        send_slots();
        check_scenario("reset_mid");
    endtask

    task automatic test_short_slot();
        do_reset(1'b1);
        add_slot(1'b1, WD, '0);
        add_slot(1'b0, WD, 16'h1111);
        add_slot(1'b1, WD, 16'h2222);
        add_slot(1'b0, WD, 16'h3333);
        add_slot(1'b1, 10, 16'h4444);
        add_slot(1'b0, WD, 16'h5555);
        add_slot(1'b1, WD, 16'h6666);
        add_slot(1'b0, 3, '0);
        send_slots();
        check_scenario("short_slot");
    endtask

    task automatic test_long_slot();
        do_reset(1'b1);
        add_slot(1'b1, WD, '0);
        add_slot(1'b0, 40, 16'h0F0F);
        add_slot(1'b1, WD, 16'hF0F0);
        add_slot(1'b0, 3, '0);
        send_slots();
        check_scenario("long_slot");
    endtask

    task automatic test_mid_right();
        do_reset(1'b1);
        add_slot(1'b1, 7, 16'hBEEF);
        add_slot(1'b0, WD, 16'h4321);
        add_slot(1'b1, WD, 16'h8765);
        add_slot(1'b0, 3, '0);
        send_slots();
        check_scenario("mid_right");
    endtask

    task automatic test_random();
        int len;
        for (int r = 0; r < 3; r++) begin
            do_reset(1'($urandom));
            add_slot(1'b1, $urandom_range(1, WD), BS'($urandom));
            for (int i = 0; i < 12; i++) begin
                if ($urandom_range(0, 1) == 0) len = WD;
                else len = $urandom_range(1, 2 * WD + 6);
                add_slot(1'(i % 2 == 1), len, BS'($urandom));
            end
            add_slot(1'b0, 3, '0);
            send_slots();
            check_scenario($sformatf("random%0d", r));
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_extremes();
        test_reset_mid();
        test_short_slot();
        test_long_slot();
        test_mid_right();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
